// File: rtl/tx_uart_if.sv
// rtl/tx_uart_if.sv - Request/strobe inputs and serial line/status outputs of tx_uart
interface tx_uart_if #(
  parameter int NB_DATA = 8
);
  logic               i_tick;
  logic               i_start;
  logic [NB_DATA-1:0] i_data;
  logic               o_tx;
  logic               o_busy;
  logic               o_done;

  modport master (output i_tick, i_start, i_data, input o_tx, o_busy, o_done);
  modport slave  (input i_tick, i_start, i_data, output o_tx, o_busy, o_done);
endinterface

// File: rtl/tx_uart.sv
// rtl/tx_uart.sv - 16x-oversampled UART transmitter with optional parity and 1/2 stop bits
module tx_uart #(
  parameter int NB_DATA = 8,
  parameter int SB_TICK = 16,
  parameter int PARITY  = 0
) (
  input  logic     i_clk,
  input  logic     i_reset_n,
  tx_uart_if.slave bus
);
  // The stop bit may run up to 32 ticks, so the shared tick counter widens with it.
  localparam int TW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int BW = $clog2(NB_DATA);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [TW-1:0]      tick_q, tick_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [NB_DATA-1:0] shift_q, shift_d;
  logic               par_q, par_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               data_par;

  // Parity is taken from the accepted word, not from the shifting copy.
  assign data_par = (PARITY == 2) ? ~(^bus.i_data) : (^bus.i_data);

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (bus.i_start) begin
          state_d = ST_START;
          shift_d = bus.i_data;
          par_d   = data_par;
          tick_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_START: begin
        if (bus.i_tick) begin
          if (tick_q == TW'(15)) begin
            tick_d  = '0;
            state_d = ST_DATA;
            tx_d    = shift_q[0];
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (bus.i_tick) begin
          if (tick_q == TW'(15)) begin
            tick_d = '0;
            if (bit_q == BW'(NB_DATA - 1)) begin
              if (PARITY != 0) begin
                state_d = ST_PARITY;
                tx_d    = par_q;
              end else begin
                state_d = ST_STOP;
                tx_d    = 1'b1;
              end
            end else begin
              shift_d = shift_q >> 1;
              bit_d   = bit_q + 1'b1;
              tx_d    = shift_q[1];
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bus.i_tick) begin
          if (tick_q == TW'(15)) begin
            tick_d  = '0;
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (bus.i_tick) begin
          if (tick_q == TW'(SB_TICK - 1)) begin
            tick_d  = '0;
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tick_d  = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.o_tx   = tx_q;
  assign bus.o_busy = busy_q;
  assign bus.o_done = done_q;
endmodule

// File: doc/tx_uart.md
TX_UART -- requirements
Module: tx_uart

Interface
REQ-001 Parameter NB_DATA, default 8, data bits per frame (5..9).
REQ-002 Parameter SB_TICK, default 16, stop-bit length in i_tick pulses (16 = 1 stop bit, 32 = 2 stop bits).
REQ-003 Parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 i_clk  input  1  system clock; all state changes on rising edge.
REQ-005 i_reset_n  input  1  asynchronous, active-low reset.
REQ-006 i_tick  input  1  one-clock 16x-oversampling baud strobe from the shared baud generator.
REQ-007 i_start  input  1  request to transmit i_data.
REQ-008 i_data  input  NB_DATA  byte to transmit; sampled only on accept.
REQ-009 o_tx  output  1  serial line, idle high, registered.
REQ-010 o_busy  output  1  high from accept until end of stop bit.
REQ-011 o_done  output  1  one-clock pulse at frame completion.

Function
REQ-012 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-013 Accept: in IDLE with i_start=1 at a rising edge, the block SHALL latch i_data into a shift register, clear tick and bit counters, enter START, and assert o_busy from the next cycle.
REQ-014 o_tx SHALL be registered and SHALL change only on state/bit transitions: 0 in START, current LSB in DATA, parity bit in PARITY, 1 in STOP and IDLE.
REQ-015 o_tx SHALL drive 0 starting the first clock after accept (one-clock latency).
REQ-016 Each START, DATA and PARITY bit SHALL last exactly 16 i_tick pulses; the 4-bit tick counter SHALL increment only on i_tick and wrap 15->0 at bit end.
REQ-017 Clock cycles without i_tick SHALL hold all counters, the shift register and o_tx unchanged.
REQ-018 DATA SHALL send bits LSB first, shifting right once per bit; after NB_DATA bits it SHALL go to PARITY if PARITY!=0, else to STOP.
REQ-019 Parity bit SHALL be XOR of the latched data for even, its inverse for odd, computed from the value latched at accept.
REQ-020 STOP SHALL last SB_TICK i_tick pulses, with the tick counter widened as needed for SB_TICK up to 32.
REQ-021 On the last STOP tick the FSM SHALL return to IDLE, drop o_busy, and pulse o_done for exactly one clock in that same edge's following cycle.
REQ-022 i_start while o_busy=1 SHALL be ignored; i_data changes during a frame SHALL not affect it.
REQ-023 i_start asserted during the o_done cycle (state IDLE) SHALL be accepted, giving back-to-back frames with no idle gap beyond one clock.
REQ-024 Unused/illegal state encodings SHALL recover to IDLE on the next clock with o_tx=1.
REQ-025 i_start and i_tick high in the accept cycle: the tick SHALL not count toward the start bit.

Reset
REQ-026 While i_reset_n=0, the block SHALL immediately (asynchronously) force state IDLE, o_tx=1, o_busy=0, o_done=0, counters and shift register 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no o_done; after release the block SHALL accept a new i_start on the first rising edge.

Verification
REQ-028 NB_DATA=8, PARITY=0, i_tick every 4 clocks, send 0xA5 -> o_tx = 0, 1,0,1,0,0,1,0,1, 1, each bit 16 ticks (64 clocks), o_done single pulse after stop, o_busy high throughout.
REQ-029 PARITY=1 send 0xA5 -> parity bit 0; PARITY=2 send 0xA5 -> parity bit 1; PARITY=1 send 0x07 -> parity bit 1.
REQ-030 Two frames 0x3C then 0xC3 with i_start held across o_done -> second start bit begins 1 clock after o_done, no extra idle, both decode correctly.
REQ-031 i_start pulsed with i_data=0xFF midway through a 0x00 frame -> frame stays 0x00, no extra frame, one o_done.
REQ-032 i_reset_n low for 3 clocks during data bit 3 -> o_tx=1 within the reset cycle without a clock edge, o_busy=0, no o_done; next 0x5A frame transmits correctly.
REQ-033 SB_TICK=32 -> stop high for 32 ticks before o_done; i_tick held low for 100 clocks mid-bit -> o_tx and counters frozen.
